// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scan controller sharing one BCD
// decoder across DIGITS positions, with a frame-stable display copy.
// Ports: iClk, iRst (sync, active-high), iData[4*DIGITS] BCD nibbles,
//   iLoad request pulse, oAck visible pulse, oDigit decoder nibble
//   (4'hF = blank), oAn active-low digit enables, oFrame frame-start pulse.
// Option: define DISPLAY_SCAN_LZ_BLANK_EN for leading-zero suppression.
module display_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [4*DIGITS-1:0]   iData,
  input  logic                  iLoad,
  output logic                  oAck,
  output logic [3:0]            oDigit,
  output logic [DIGITS-1:0]     oAn,
  output logic                  oFrame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state;
  state_t              stateNext;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cntNext;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idxNext;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] pend;
  logic                pendV;
  logic                boundary;
  logic [3:0]          digitSel;
  logic [DIGITS-1:0]   anSel;
  logic [DIGITS-1:0]   lz;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    idxNext   = idx;
    unique case (state)
      BLANK: begin
        stateNext = SHOW;
        cntNext   = CW'(1);
      end
      SHOW: begin
        if (cnt == CMAX) begin
          stateNext = BLANK;
          cntNext   = '0;
          idxNext   = (idx == IMAX) ? '0 : idx + IW'(1);
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: stateNext = BLANK;
    endcase
  end

  // Outputs trail the slot registers by one edge, so the edge that sees
  // BLANK on digit 0 is the one that starts a frame on the outputs.
  assign boundary = (state == BLANK) && (idx == '0);

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
  logic allZero;
  always_comb begin
    lz      = '0;
    allZero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allZero = allZero && (disp[4*k +: 4] == 4'h0);
      lz[k]   = allZero;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    digitSel = 4'hF;
    anSel    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        digitSel = lz[k] ? 4'hF : disp[4*k +: 4];
        anSel[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state  <= BLANK;
      cnt    <= '0;
      idx    <= '0;
      disp   <= '0;
      pend   <= '0;
      pendV  <= 1'b0;
      oAn    <= '1;
      oDigit <= 4'hF;
      oAck   <= 1'b0;
      oFrame <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      idx    <= idxNext;
      oFrame <= boundary;
      oAck   <= 1'b0;
      if (state == SHOW) begin
        oAn    <= anSel;
        oDigit <= digitSel;
      end else begin
        oAn    <= '1;
        oDigit <= 4'hF;
      end
      if (boundary) begin
        pendV <= 1'b0;
        // A load coinciding with the boundary wins over the pending copy.
        if (iLoad) begin
          disp <= iData;
          oAck <= 1'b1;
        end else if (pendV) begin
          disp <= pend;
          oAck <= 1'b1;
        end
      end else if (iLoad) begin
        pend  <= iData;
        pendV <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed bench for display_scan (DIGITS=4, SCAN_DIV=4).
// Expected per-cycle outputs are queued as stimulus is driven.
module tb_display_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iLoad;
  logic [15:0] iData;
  logic        oAck;
  logic        oFrame;
  logic [3:0]  oDigit;
  logic [3:0]  oAn;

  typedef struct {
    logic [3:0] an;
    logic [3:0] dig;
    logic       ack;
    logic       frame;
    string      tag;
    int         n;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          stepN  = 0;
  logic [15:0] mDisp;
  logic [15:0] mPend;
  logic        mPendV;

  display_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iData  (iData),
    .iLoad  (iLoad),
    .oAck   (oAck),
    .oDigit (oDigit),
    .oAn    (oAn),
    .oFrame (oFrame)
  );

  always #5 iClk = ~iClk;

  function automatic logic [3:0] expDigit(logic [15:0] v, int s);
    logic [15:0] t;
    t = v >> (4 * s);
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
    if (s > 0 && t == 16'h0) return 4'hF;
`endif
    return t[3:0];
  endfunction

  task automatic chk(string tag, int n, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk({m.tag, ".an"}, m.n, oAn, m.an);
      chk({m.tag, ".digit"}, m.n, oDigit, m.dig);
      chk({m.tag, ".ack"}, m.n, {3'b0, oAck}, {3'b0, m.ack});
      chk({m.tag, ".frame"}, m.n, {3'b0, oFrame}, {3'b0, m.frame});
    end
  end

  task automatic tick(input logic rst, input logic load,
                      input logic [15:0] data, input string tag);
    exp_t e;
    int   p;
    int   s;
    iRst  = rst;
    iLoad = load;
    iData = data;
    e.tag = tag;
    e.n   = stepN++;
    e.ack = 1'b0;
    if (rst) begin
      e.an    = 4'hF;
      e.dig   = 4'hF;
      e.frame = 1'b0;
      cyc     = 0;
      mDisp   = '0;
      mPend   = '0;
      mPendV  = 1'b0;
    end else begin
      p = cyc % FRAME;
      s = p / SCAN_DIV;
      cyc++;
      e.frame = (p == 0);
      if (p == 0) begin
        if (load) begin
          mDisp = data;
          e.ack = 1'b1;
        end else if (mPendV) begin
          mDisp = mPend;
          e.ack = 1'b1;
        end
        mPendV = 1'b0;
      end else if (load) begin
        mPend  = data;
        mPendV = 1'b1;
      end
      if (p % SCAN_DIV == 0) begin
        e.an  = 4'hF;
        e.dig = 4'hF;
      end else begin
        e.an  = ~(4'b0001 << s);
        e.dig = expDigit(mDisp, s);
      end
    end
    sb.push_back(e);
    @(posedge iClk);
    #1;
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) tick(1'b0, 1'b0, 16'h0, tag);
  endtask

  initial begin
    iRst  = 1'b1;
    iLoad = 1'b0;
    iData = '0;
    repeat (3) tick(1'b1, 1'b0, 16'h0, "reset");
    run(5, "f0");
    tick(1'b0, 1'b1, 16'h1234, "load1234");
    run(10, "f0");
    run(9, "scan");
    tick(1'b0, 1'b1, 16'h5678, "load5678");
    run(6, "deferred");
    run(3, "f2");
    tick(1'b0, 1'b1, 16'h1111, "load1111");
    run(5, "f2");
    tick(1'b0, 1'b1, 16'h2222, "load2222");
    run(6, "f2");
    run(16, "overwrite");
    tick(1'b0, 1'b1, 16'h9999, "collide");
    run(4, "f4");
    tick(1'b0, 1'b1, 16'h0070, "load0070");
    run(10, "f4");
    run(6, "lz0070");
    tick(1'b0, 1'b1, 16'h0000, "load0000");
    run(9, "lz0070");
    run(2, "lz0000");
    tick(1'b0, 1'b1, 16'h00AB, "load00AB");
    run(13, "lz0000");
    run(5, "nonbcd");
    tick(1'b0, 1'b1, 16'h1357, "load1357");
    run(2, "nonbcd");
    repeat (2) tick(1'b1, 1'b0, 16'h0, "midreset");
    run(32, "postreset");
    @(negedge iClk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scan controller that shares one 7-segment BCD decoder between `DIGITS` digit positions. It holds a frame-stable copy of the displayed value, steps through the digits at a fixed slot rate, and drives the shared decoder's 4-bit input and the active-low digit enables. It inserts one dead-time cycle per slot to prevent ghosting. It sits between the note/score logic, which supplies BCD values, and the board's seven-segment display through the shared decoder.

## Interface
- `DIGITS`, default 4: number of digit positions, legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles per digit slot, minimum 2.
- `iClk` input, 1 bit: clock; all state updates on its rising edge.
- `iRst` input, 1 bit: reset. Synchronous and active-high.
- `iData` input, 4*DIGITS bits: BCD nibbles. Digit k is `iData[4k+3:4k]`; digit 0 is the rightmost digit.
- `iLoad` input, 1 bit: single-cycle request to display `iData`.
- `oAck` output, 1 bit: one-cycle pulse when a requested value becomes visible.
- `oDigit` output, 4 bits: nibble to the shared decoder. `4'hF` means blank, because the decoder default case turns all segments off.
- `oAn` output, DIGITS bits: active-low digit enables; at most one bit is low.
- `oFrame` output, 1 bit: one-cycle pulse at the start of each frame.

## Operation
- Internal registers:
  - slot counter `cnt`, range 0..SCAN_DIV-1;
  - digit index `idx`, range 0..DIGITS-1;
  - display register `disp`, 4*DIGITS bits;
  - pending register `pend`, 4*DIGITS bits;
  - flag `pend_v`.
- Two-state slot FSM:
  - **BLANK**: lasts for `cnt==0`.
  - **SHOW**: lasts for `cnt` = 1..SCAN_DIV-1.
  - BLANK→SHOW always follows after 1 cycle.
  - When SHOW reaches `cnt==SCAN_DIV-1`, the FSM returns to BLANK, `cnt` resets to 0, and `idx` increments, wrapping from DIGITS-1 to 0.
- Outputs are registered and reflect the current state and slot:
  - In BLANK: `oAn` is all ones and `oDigit=4'hF`.
  - In SHOW: `oAn[idx]=0`, with all other bits 1, and `oDigit=disp[4idx+3:4idx]`.
- **Load handshake:**
  - `iLoad=1` captures `iData` into `pend` and sets `pend_v`.
  - A later `iLoad` before the frame boundary overwrites `pend`. Only the last value is shown, and only one `oAck` is issued.
- **Frame boundary** is the transition into BLANK with `idx=0`.
  - If `pend_v` is set, `disp <= pend`, `pend_v` clears, and `oAck` pulses during that BLANK cycle.
  - If `iLoad` is asserted in the same cycle that creates the boundary, its `iData` is loaded into `disp` directly and acknowledged in that frame.
- `disp` never changes mid-frame, so there is no tearing.
- Non-BCD nibbles `4'hA`..`4'hE` pass through unchanged; the decoder blanks them.
- Arithmetic:
  - `cnt` width is `$clog2(SCAN_DIV)`, and `idx` width is `max(1,$clog2(DIGITS))`.
  - There is no overflow past the terminal values.
- With DIGITS=1, `idx` stays at 0 and every slot is a frame.

## Timing
- Reset applies synchronously, on the first edge with `iRst=1`. Reset values:
  - Registers: `cnt=0`, `idx=0`, state BLANK, `disp=0`, `pend=0`, `pend_v=0`.
  - Outputs: `oAn` all ones, `oDigit=4'hF`, `oAck=0`, `oFrame=0`.
- The first edge after `iRst` deasserts is frame start 0, so `oFrame=1` on that cycle.
- Reset asserted mid-operation aborts any slot and discards any pending load; no `oAck` is issued for the discarded value.
- Slot period is SCAN_DIV cycles, and frame period is DIGITS*SCAN_DIV cycles.
- `oFrame` and `oAck` are high exactly during the BLANK cycle of slot 0.
- Load latency, from `iLoad` to `oAck`, is 1 to DIGITS*SCAN_DIV cycles.
- The new value appears on `oDigit` one cycle after `oAck`, in the SHOW cycles of slot 0.

## Configuration
- Macro `DISPLAY_SCAN_LZ_BLANK_EN` enables leading-zero suppression.
  - **Defined:** during SHOW, digit k outputs `4'hF` when it and every digit above it in `disp` are `4'h0`. Digit 0 is never suppressed. `oAn[idx]` is still driven low, so the timing is unchanged.
  - **Undefined:** every digit shows `disp` unchanged, including leading zeros. No extra logic is compiled in.

## Test plan
All scenarios use DIGITS=4 and SCAN_DIV=4.
- **Reset:** hold `iRst` for 3 cycles, then release.
  - During reset: `oAn=4'b1111`, `oDigit=F`, `oAck=0`.
  - First cycle after release: `oFrame=1`.
  - Next 3 cycles: `oAn=4'b1110`, `oDigit=0`.
- **Scan order:** load `16'h1234`.
  - SHOW sequence `oAn`/`oDigit`: 1110/4, 1101/3, 1011/2, 0111/1.
  - Each slot is preceded by one BLANK cycle: `oAn=1111`, `oDigit=F`.
  - Frame period is 16 cycles.
- **Deferred load:** pulse `iLoad` with `16'h5678` during slot 2.
  - Slots 2 and 3 still show the old value.
  - `oAck=1` coincides with the next `oFrame`.
  - The next SHOW cycles on digit 0 give `oDigit=8`.
- **Overwrite:** pulse `iLoad` with `16'h1111`, then `16'h2222`, in the same frame.
  - Exactly one `oAck` is issued.
  - Digits show 2; 1 is never displayed.
- **Boundary collision:** assert `iLoad` with `16'h9999` in the cycle entering slot 0 BLANK.
  - `oAck` pulses in that same BLANK cycle.
  - The next 3 cycles give `oDigit=9`.
- **Leading-zero suppression:** load `16'h0070` with `DISPLAY_SCAN_LZ_BLANK_EN` defined.
  - Digits 3, 2, 1, 0 show F, F, 7, 0.
  - Without the macro they show 0, 0, 7, 0.
  - Loading `16'h0000` with the macro defined shows F, F, F, 0.
